// File: rtl/eth_tx_arb.sv
// Packet-atomic round-robin arbiter for the shared Ethernet TX stream.
// Grants at sop, holds the grant until eop is accepted, then idles IDLE_GAP cycles.
module eth_tx_arb #(
  parameter int N_SRC     = 4,
  parameter int DW        = 32,
  parameter int IDLE_GAP  = 2,
  parameter int MAX_WORDS = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SRC-1:0]    i_src_sop,
  input  logic [N_SRC-1:0]    i_src_eop,
  input  logic [N_SRC-1:0]    i_src_vld,
  input  logic [N_SRC*DW-1:0] i_src_data,
  output logic [N_SRC-1:0]    o_src_rdy,
  output logic                o_eth_sop,
  output logic                o_eth_eop,
  output logic                o_eth_vld,
  output logic [DW-1:0]       o_eth_data,
  input  logic                i_eth_rdy,
  output logic [N_SRC-1:0]    o_grant,
  output logic                o_busy,
  output logic [15:0]         o_last_len,
  output logic                o_pkt_done,
  output logic                o_overrun
);

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int XW = IW + 1;
  localparam logic [IW-1:0] LAST_RST = IW'(N_SRC - 1);
  localparam logic [3:0] GAP_LAST = 4'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   len_q, len_d;
  logic [3:0]    gap_q, gap_d;
  logic          ovr_q, ovr_d;

  logic [N_SRC-1:0] req;
  logic [IW-1:0]    sel;
  logic [XW-1:0]    idx;
  logic             found;
  logic             busy;
  logic             xfer;

  assign req = i_src_vld & i_src_sop;

  // Search starts one past the last served source, wrapping at N_SRC.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = {1'b0, last_q} + XW'(k);
      if (idx >= XW'(N_SRC)) idx = idx - XW'(N_SRC);
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    busy       = (state_q == S_BUSY);
    o_eth_sop  = busy & i_src_sop[grant_q];
    o_eth_eop  = busy & i_src_eop[grant_q];
    o_eth_vld  = busy & i_src_vld[grant_q];
    o_eth_data = busy ? i_src_data[int'(grant_q)*DW +: DW] : '0;
    o_src_rdy  = '0;
    o_grant    = '0;
    if (busy) begin
      o_src_rdy[grant_q] = i_eth_rdy;
      o_grant[grant_q]   = 1'b1;
    end
    xfer       = busy & i_src_vld[grant_q] & i_eth_rdy;
    o_pkt_done = xfer & i_src_eop[grant_q];
    o_busy     = (state_q != S_IDLE);
    o_last_len = len_q;
    o_overrun  = ovr_q;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    gap_d   = gap_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = sel;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (xfer) begin
          if (i_src_eop[grant_q]) begin
            len_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            cnt_d   = '0;
            last_d  = grant_q;
            gap_d   = '0;
            state_d = (IDLE_GAP > 0) ? S_GAP : S_IDLE;
          end else begin
            if (32'(cnt_q) >= MAX_WORDS) ovr_d = 1'b1;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else gap_d = gap_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      len_q   <= '0;
      gap_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule

// File: tb/tb_eth_tx_arb.sv
// Randomised and directed bench for eth_tx_arb against a cycle-level
// behavioural model plus a per-source packet scoreboard.
module tb_eth_tx_arb;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int GAP  = 2;
  localparam int MAXW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    src_sop = '0;
  logic [N-1:0]    src_eop = '0;
  logic [N-1:0]    src_vld = '0;
  logic [N*DW-1:0] src_data = '0;
  logic [N-1:0]    src_rdy;
  logic            eth_sop, eth_eop, eth_vld;
  logic [DW-1:0]   eth_data;
  logic            eth_rdy = 1'b1;
  logic [N-1:0]    grant;
  logic            busy;
  logic [15:0]     last_len;
  logic            pkt_done, overrun;

  always #5 clk = ~clk;

  eth_tx_arb #(
    .N_SRC(N), .DW(DW), .IDLE_GAP(GAP), .MAX_WORDS(MAXW)
  ) dut (
    .clk(clk), .rst(rst),
    .i_src_sop(src_sop), .i_src_eop(src_eop),
    .i_src_vld(src_vld), .i_src_data(src_data),
    .o_src_rdy(src_rdy),
    .o_eth_sop(eth_sop), .o_eth_eop(eth_eop),
    .o_eth_vld(eth_vld), .o_eth_data(eth_data),
    .i_eth_rdy(eth_rdy),
    .o_grant(grant), .o_busy(busy),
    .o_last_len(last_len), .o_pkt_done(pkt_done),
    .o_overrun(overrun)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // source generators
  int lens[N][$];
  int pos[N];
  int gen_pid[N];
  int dly[N];
  bit gv[N];
  bit junk[N];
  bit vld_rand = 0;

  // scoreboard
  int sb_len[N][$];
  int sb_pid[N];
  int sb_idx[N];
  int done_src[$];
  int sop_cyc[$];
  int eop_cyc[$];

  // behavioural model
  int m_cur, m_gap, m_last, m_cnt, m_len;
  bit m_ovr;
  bit [N-1:0] fire;

  function automatic void model_reset();
    m_cur = -1; m_gap = 0; m_last = N - 1;
    m_cnt = 0; m_len = 0; m_ovr = 0;
  endfunction

  function automatic void gen_reset();
    for (int s = 0; s < N; s++) begin
      lens[s].delete(); sb_len[s].delete();
      pos[s] = 0; gen_pid[s] = 0; dly[s] = 0; gv[s] = 1; junk[s] = 0;
      sb_pid[s] = 0; sb_idx[s] = 0;
    end
  endfunction

  function automatic void drive();
    for (int s = 0; s < N; s++) begin
      src_sop[s] = 0; src_eop[s] = 0; src_vld[s] = 0;
      src_data[s*DW +: DW] = '0;
      if (lens[s].size() > 0 && dly[s] == 0) begin
        src_sop[s] = (pos[s] == 0);
        src_eop[s] = (pos[s] == lens[s][0] - 1);
        src_vld[s] = (pos[s] == 0) || gv[s];
        src_data[s*DW +: DW] = {8'(s), 8'(gen_pid[s]), 16'(pos[s])};
      end else if (junk[s]) begin
        src_vld[s] = 1;
        src_data[s*DW +: DW] = 32'hDEAD_0000 | 32'(s);
      end
    end
  endfunction

  function automatic void advance();
    for (int s = 0; s < N; s++) begin
      if (fire[s]) begin
        pos[s]++;
        if (pos[s] == lens[s][0]) begin
          void'(lens[s].pop_front());
          pos[s] = 0; gen_pid[s]++;
          dly[s] = vld_rand ? $urandom_range(0, 3) : 0;
        end
        gv[s] = vld_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end else begin
        if (dly[s] > 0) dly[s]--;
        if (!gv[s]) gv[s] = vld_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  endfunction

  task automatic sample();
    logic [N-1:0] e_grant, e_rdy;
    logic e_busy, e_sop, e_eop, e_vld, e_done, xfer;
    logic [DW-1:0] e_data;
    int s;
    e_grant = '0; e_rdy = '0; e_busy = 0; e_sop = 0; e_eop = 0;
    e_vld = 0; e_done = 0; xfer = 0; e_data = '0;
    if (m_cur >= 0) begin
      e_busy = 1; e_grant[m_cur] = 1; e_rdy[m_cur] = eth_rdy;
      e_sop = src_sop[m_cur]; e_eop = src_eop[m_cur];
      e_vld = src_vld[m_cur]; e_data = src_data[m_cur*DW +: DW];
      xfer = e_vld && eth_rdy;
      e_done = xfer && e_eop;
    end else if (m_gap > 0) e_busy = 1;
    check("grant", grant, e_grant);
    check("busy", busy, e_busy);
    check("src_rdy", src_rdy, e_rdy);
    check("eth_vld", eth_vld, e_vld);
    check("pkt_done", pkt_done, e_done);
    check("last_len", last_len, m_len);
    check("overrun", overrun, m_ovr);
    if (!(m_cur < 0 && m_gap > 0)) begin
      check("eth_sop_eop", {eth_sop, eth_eop}, {e_sop, e_eop});
      check("eth_data", eth_data, e_data);
    end
    if (xfer && !rst) begin
      s = m_cur;
      check("sb_word", eth_data, {8'(s), 8'(sb_pid[s]), 16'(sb_idx[s])});
      if (sb_idx[s] == 0) sop_cyc.push_back(cyc);
      if (eth_eop) begin
        if (sb_len[s].size() == 0) check("sb_extra", sb_len[s].size(), 1);
        else begin
          check("sb_len", sb_idx[s] + 1, sb_len[s][0]);
          void'(sb_len[s].pop_front());
        end
        sb_idx[s] = 0; sb_pid[s]++;
        eop_cyc.push_back(cyc); done_src.push_back(s);
      end else sb_idx[s]++;
    end
    fire = '0;
    if (xfer) fire[m_cur] = 1;
    if (rst) model_reset();
    else if (m_cur >= 0) begin
      if (xfer) begin
        if (e_eop) begin
          m_len = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
          m_cnt = 0; m_last = m_cur; m_cur = -1; m_gap = GAP;
        end else begin
          if (m_cnt >= MAXW) m_ovr = 1;
          if (m_cnt < 65535) m_cnt++;
        end
      end
    end else if (m_gap > 0) m_gap--;
    else begin
      for (int k = 1; k <= N; k++) begin
        s = (m_last + k) % N;
        if (src_vld[s] && src_sop[s]) begin
          m_cur = s;
          break;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
    if (rst) gen_reset();
    else advance();
    drive();
  endtask

  task automatic add_pkt(int s, int len);
    lens[s].push_back(len);
    sb_len[s].push_back(len);
    drive();
  endtask

  function automatic bit all_idle();
    bit r;
    r = (m_cur < 0) && (m_gap == 0);
    for (int s = 0; s < N; s++) if (lens[s].size() > 0) r = 0;
    return r;
  endfunction

  task automatic wait_idle(int budget);
    int n = 0;
    while (!all_idle() && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", all_idle(), 1);
  endtask

  task automatic wait_words(int s, int w, int budget);
    int n = 0;
    while (sb_idx[s] < w && n < budget) begin
      tick();
      n++;
    end
    check("word_timeout", sb_idx[s] >= w, 1);
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  function automatic void clear_logs();
    done_src.delete(); sop_cyc.delete(); eop_cyc.delete();
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    logic [31:0] hold;
    model_reset();
    gen_reset();
    drive();
    @(posedge clk);
    #1;
    tick();
    rst = 0;
    tick();

    // single 12-word frame from source 0
    clear_logs();
    c0 = cyc;
    add_pkt(0, 12);
    wait_idle(100);
    check("arp_done_cnt", done_src.size(), 1);
    if (done_src.size() == 1) begin
      check("arp_src", done_src[0], 0);
      check("arp_latency", sop_cyc[0] - c0, 1);
    end
    check("arp_len", last_len, 12);

    // simultaneous requests from 0, 1, 3 right after reset
    do_reset();
    clear_logs();
    lens[0].push_back(3); sb_len[0].push_back(3);
    lens[1].push_back(3); sb_len[1].push_back(3);
    add_pkt(3, 3);
    wait_idle(100);
    check("rr_cnt", done_src.size(), 3);
    if (done_src.size() == 3) begin
      check("rr_order0", done_src[0], 0);
      check("rr_order1", done_src[1], 1);
      check("rr_order2", done_src[2], 3);
      for (int k = 0; k < 2; k++)
        check("rr_gap", sop_cyc[k+1] - eop_cyc[k], GAP + 2);
    end

    // downstream stall mid-packet
    clear_logs();
    add_pkt(2, 8);
    wait_words(2, 3, 20);
    hold = {8'd2, 8'(sb_pid[2]), 16'd3};
    eth_rdy = 0;
    repeat (5) begin
      #1;
      check("stall_data", eth_data, hold);
      check("stall_vld", eth_vld, 1);
      check("stall_rdy", src_rdy, 0);
      tick();
    end
    eth_rdy = 1;
    wait_idle(100);
    check("bp_len", last_len, 8);
    check("bp_done_cnt", done_src.size(), 1);

    // valid without sop is ignored, then sop is served
    junk[2] = 1;
    drive();
    repeat (6) tick();
    #1;
    check("junk_grant", grant, 0);
    check("junk_rdy", src_rdy, 0);
    clear_logs();
    add_pkt(2, 3);
    wait_idle(100);
    check("junk_len", last_len, 3);
    check("junk_done_cnt", done_src.size(), 1);
    junk[2] = 0;
    drive();
    tick();

    // overrun at MAX_WORDS with a 6-word packet
    do_reset();
    #1;
    check("ovr_clear", overrun, 0);
    add_pkt(1, 6);
    wait_words(1, 4, 20);
    #1;
    check("ovr_pre", overrun, 0);
    tick();
    #1;
    check("ovr_set", overrun, 1);
    wait_idle(100);
    check("ovr_len", last_len, 6);
    check("ovr_sticky", overrun, 1);

    // reset during word 3
    add_pkt(3, 8);
    wait_words(3, 2, 20);
    rst = 1;
    tick();
    rst = 0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_vld", eth_vld, 0);
    check("rst_len", last_len, 0);
    check("rst_ovr", overrun, 0);
    tick();
    tick();

    // randomised traffic with back-pressure and source stalls
    vld_rand = 1;
    for (int i = 0; i < 600; i++) begin
      eth_rdy = ($urandom_range(0, 4) != 0);
      for (int s = 0; s < N; s++)
        if (lens[s].size() < 2 && $urandom_range(0, 9) == 0)
          add_pkt(s, $urandom_range(1, 7));
      drive();
      tick();
    end
    eth_rdy = 1;
    wait_idle(1000);
    for (int s = 0; s < N; s++) check("rand_drain", sb_len[s].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/eth_tx_arb.md
# eth_tx_arb

Packet-atomic round-robin arbiter that shares the single 32-bit Ethernet TX stream (sop/eop/vld/data with downstream ready) between up to N_SRC packet generators such as the ARP, ICMP and UDP senders. Each generator keeps its own stream interface unchanged. The arbiter grants one source at a sop word and holds that grant until the granted source's eop word is accepted. It then enforces a programmable inter-packet gap and reports per-packet status to the host-side logic.

## Interface
- N_SRC, 4: number of requesting sources (2..8).
- DW, 32: data width per source.
- IDLE_GAP, 2: forced idle cycles after each packet's eop (0..15).
- MAX_WORDS, 1024: word count at which a packet without eop flags overrun.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- i_src_sop  in  N_SRC  per-source start of packet.
- i_src_eop  in  N_SRC  per-source end of packet.
- i_src_vld  in  N_SRC  per-source word valid.
- i_src_data  in  N_SRC*DW  source i occupies [i*DW +: DW].
- o_src_rdy  out  N_SRC  per-source ready (one-hot or zero).
- o_eth_sop / o_eth_eop / o_eth_vld  out  1 each  muxed stream controls.
- o_eth_data  out  DW  muxed stream data.
- i_eth_rdy  in  1  downstream ready.
- o_grant  out  N_SRC  one-hot current grant; zero when not BUSY.
- o_busy  out  1  high in BUSY or GAP.
- o_last_len  out  16  word count of the last completed packet.
- o_pkt_done  out  1  one-cycle pulse per completed packet.
- o_overrun  out  1  sticky; cleared only by rst.

## Operation
- States: IDLE, BUSY, GAP.
- A transfer occurs when a word is valid and downstream is ready (vld & rdy).
- Request i is `i_src_vld[i] & i_src_sop[i]`. A source that is valid without sop while ungranted is ignored and sees o_src_rdy[i]=0.
- IDLE:
  - All outputs are 0.
  - If any request is present, select the first requester searching from last_grant+1 upward, modulo N_SRC.
  - Register the selection as grant and go to BUSY.
- BUSY:
  - o_eth_{sop,eop,vld,data} = source[grant] inputs (combinational).
  - o_src_rdy[grant] = i_eth_rdy; all other bits of o_src_rdy are 0.
  - On each transfer, word_cnt increments, saturating at 16'hFFFF.
  - When word_cnt reaches MAX_WORDS and the current word is not eop, set o_overrun. The grant is still held until eop.
  - On a transfer with eop:
    - o_last_len <= word_cnt+1 (total words including the eop word).
    - Pulse o_pkt_done.
    - last_grant <= grant; word_cnt <= 0.
    - Go to GAP if IDLE_GAP>0, otherwise go to IDLE.
- GAP: o_eth_vld=0 and all o_src_rdy=0. Count IDLE_GAP cycles, then go to IDLE.
- The arbiter forwards the source's sop, eop and vld as-is. A source glitching sop mid-packet is not checked.

## Timing
- Reset values:
  - state=IDLE, grant=0, last_grant=N_SRC-1 (source 0 has first priority), word_cnt=0.
  - All outputs 0, including o_last_len and o_overrun.
- Arbitration latency:
  - Request visible in IDLE at cycle t → o_grant and o_eth_sop valid at t+1.
  - The source holds its sop word until rdy, so nothing is lost.
- Throughput:
  - Eop accepted at cycle t → GAP occupies t+1..t+IDLE_GAP → IDLE at t+IDLE_GAP+1 → next sop at t+IDLE_GAP+2.
  - Minimum idle on the wire is therefore IDLE_GAP+1 cycles.
- Back-pressure: i_eth_rdy=0 stalls the granted source with no data loss. State and counters hold.
- Simultaneous requests are resolved in the same IDLE cycle by round-robin order only.
- A source requesting during BUSY or GAP waits. It keeps sop and vld asserted, as generators do.
- o_pkt_done is high in the same cycle as the eop transfer.
- o_last_len updates at the clock edge ending that cycle.
- Reset mid-packet:
  - The next cycle is IDLE with outputs 0. The partial frame is abandoned downstream.
  - Sources are reset on the same rst.
- A single-word packet (sop & eop on one word) completes in one BUSY cycle with o_last_len=1.

## Test plan
- Single source 0 sends a 12-word ARP frame with i_eth_rdy=1:
  - Grant 0001 one cycle after the request.
  - 12 words appear in order; o_last_len=12; one o_pkt_done pulse.
- Sources 0, 1 and 3 request simultaneously with 3-word packets and IDLE_GAP=2:
  - Grants run 0, 1, 3.
  - Exactly 3 idle cycles separate consecutive eop and sop.
- Downstream holds i_eth_rdy=0 for 5 cycles mid-packet:
  - Data word and o_eth_vld are stable.
  - o_src_rdy[grant]=0 throughout.
  - No word is duplicated or dropped.
- Source 2 asserts vld without sop while idle:
  - No grant and o_src_rdy=0.
  - Later the same source asserts sop and is served normally.
- MAX_WORDS=4 with a 6-word packet:
  - o_overrun sets when word_cnt reaches 4 (the 5th word transfers) and stays set.
  - o_last_len=6.
- rst asserted during word 3 of a packet: next cycle state is IDLE, all outputs 0, and o_last_len=0.
